// File: rtl/agc_pkg.sv
// Shared types and clock-rate defaults for the automatic gain controller blocks.
package agc_pkg;

    // Gain code: 00 = lowest gain, 11 = highest gain.
    typedef logic [1:0] gain_t;

    // Phases of the break-before-make gain switch.
    typedef enum logic [1:0] {
        STEADY,
        BREAK,
        SELECT,
        SETTLE
    } sw_state_t;

    // Defaults for a 200 MHz ADC clock: 200 ns break, 10 us settle.
    localparam int DEF_BREAK_CYCLES  = 40;
    localparam int DEF_SETTLE_CYCLES = 2000;

    // Bits needed for a counter that runs 0 .. longest-1, never less than one bit.
    function automatic int timer_width(input int break_cycles, input int settle_cycles);
        int longest;
        int w;
        longest = (break_cycles > settle_cycles) ? break_cycles : settle_cycles;
        w = 1;
        while ((1 << w) < longest) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable up-counter with a terminal-count flag; one instance serves both
// the break interval and the settle interval of the gain switch.
module settle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             adc_clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Load has priority over counting so a new interval always starts cleanly.
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == terminal);

endmodule

// File: rtl/gain_switch_sequencer.sv
// Drives the analog gain mux with a break-before-make sequence and flags ADC
// samples as valid only once the analog chain has settled at the new gain.
module gain_switch_sequencer
    import agc_pkg::*;
#(
    parameter int BREAK_CYCLES  = DEF_BREAK_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = 16
) (
    input  logic             adc_clk,
    input  logic             rst,
    input  logic [1:0]       gain_req,
    input  logic             gain_stable,
    output logic             sw_en,
    output logic [1:0]       sw_sel,
    output logic [1:0]       gain_applied,
    output logic             data_valid,
    output logic             gain_locked,
    output logic             busy,
    output logic [CNT_W-1:0] switch_count
);

    localparam int                TMR_W       = timer_width(BREAK_CYCLES, SETTLE_CYCLES);
    localparam logic [TMR_W-1:0]  BREAK_LAST  = TMR_W'(BREAK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  COUNT_MAX   = '1;

    sw_state_t        state;
    sw_state_t        state_nxt;
    gain_t            target;
    gain_t            target_nxt;
    gain_t            sw_sel_nxt;
    gain_t            gain_applied_nxt;
    logic             sw_en_nxt;
    logic             data_valid_nxt;
    logic [CNT_W-1:0] switch_count_nxt;
    logic             powerup;
    logic             powerup_nxt;

    logic             tmr_load;
    logic             tmr_inc;
    logic [TMR_W-1:0] tmr_terminal;
    logic [TMR_W-1:0] tmr_count;
    logic             tmr_tc;

    settle_timer #(
        .WIDTH (TMR_W)
    ) u_settle_timer (
        .adc_clk  (adc_clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val ('0),
        .inc      (tmr_inc),
        .terminal (tmr_terminal),
        .count    (tmr_count),
        .tc       (tmr_tc)
    );

    // Next-state and next-output decisions; requests are only looked at in STEADY.
    always_comb begin
        state_nxt        = state;
        target_nxt       = target;
        sw_en_nxt        = sw_en;
        sw_sel_nxt       = sw_sel;
        gain_applied_nxt = gain_applied;
        data_valid_nxt   = data_valid;
        switch_count_nxt = switch_count;
        powerup_nxt      = powerup;
        tmr_load         = 1'b0;
        tmr_inc          = 1'b0;
        tmr_terminal     = SETTLE_LAST;

        case (state)
            STEADY: begin
                if (gain_req != gain_applied) begin
                    target_nxt     = gain_req;
                    sw_en_nxt      = 1'b0;
                    data_valid_nxt = 1'b0;
                    tmr_load       = 1'b1;
                    state_nxt      = BREAK;
                end
            end
            BREAK: begin
                tmr_terminal = BREAK_LAST;
                tmr_inc      = 1'b1;
                if (tmr_tc) begin
                    sw_sel_nxt = target;
                    state_nxt  = SELECT;
                end
            end
            SELECT: begin
                sw_en_nxt        = 1'b1;
                gain_applied_nxt = target;
                tmr_load         = 1'b1;
                state_nxt        = SETTLE;
            end
            SETTLE: begin
                tmr_inc = 1'b1;
                if (tmr_tc) begin
                    state_nxt      = STEADY;
                    data_valid_nxt = 1'b1;
                    powerup_nxt    = 1'b0;
                    if (!powerup && (switch_count != COUNT_MAX)) begin
                        switch_count_nxt = switch_count + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = SETTLE;
            end
        endcase
    end

    // State and registered outputs; reset restarts the power-up settle with the mux connected at gain 0.
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state        <= SETTLE;
            target       <= '0;
            sw_en        <= 1'b1;
            sw_sel       <= '0;
            gain_applied <= '0;
            data_valid   <= 1'b0;
            switch_count <= '0;
            powerup      <= 1'b1;
        end else begin
            state        <= state_nxt;
            target       <= target_nxt;
            sw_en        <= sw_en_nxt;
            sw_sel       <= sw_sel_nxt;
            gain_applied <= gain_applied_nxt;
            data_valid   <= data_valid_nxt;
            switch_count <= switch_count_nxt;
            powerup      <= powerup_nxt;
        end
    end

    assign busy        = (state != STEADY);
    assign gain_locked = data_valid & gain_stable & (gain_req == gain_applied);

endmodule

// File: tb/tb_gain_switch_sequencer.sv
// Randomised scoreboard bench for gain_switch_sequencer using a timeline
// reference model: each accepted request is described by its start cycle and
// the fixed offsets at which the mux opens, reselects, reconnects and settles.
module tb_gain_switch_sequencer;

    localparam int B    = 4;
    localparam int S    = 16;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          adc_clk = 1'b0;
    logic          rst;
    logic [1:0]    gain_req;
    logic          gain_stable;
    logic          sw_en;
    logic [1:0]    sw_sel;
    logic [1:0]    gain_applied;
    logic          data_valid;
    logic          gain_locked;
    logic          busy;
    logic [CW-1:0] switch_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] gain;
        int         count;
        int         at;
    } exp_t;

    exp_t sb_q[$];

    // Timeline model state
    int         cyc         = 0;
    bit         model_valid = 1'b0;
    bit         seq_valid   = 1'b0;
    int         seq_t       = 0;
    logic [1:0] seq_tgt     = '0;
    logic [1:0] old_gain    = '0;
    int         count_old   = 0;
    int         count_new   = 0;
    int         dv_rise     = 0;

    // Monitor history
    bit         have_prev = 1'b0;
    logic       prev_rst  = 1'b0;
    logic       prev_en   = 1'b0;
    logic [1:0] prev_sel  = '0;
    logic       prev_dv   = 1'b0;

    always #5 adc_clk = ~adc_clk;

    gain_switch_sequencer #(
        .BREAK_CYCLES  (B),
        .SETTLE_CYCLES (S),
        .CNT_W         (CW)
    ) dut (
        .adc_clk      (adc_clk),
        .rst          (rst),
        .gain_req     (gain_req),
        .gain_stable  (gain_stable),
        .sw_en        (sw_en),
        .sw_sel       (sw_sel),
        .gain_applied (gain_applied),
        .data_valid   (data_valid),
        .gain_locked  (gain_locked),
        .busy         (busy),
        .switch_count (switch_count)
    );

    // Expected outputs for cycle c, read off the current sequence timeline
    function automatic bit exp_dv(input int c);
        return model_valid && (c >= dv_rise);
    endfunction

    function automatic bit exp_en(input int c);
        return !(seq_valid && (c >= seq_t + 1) && (c <= seq_t + B + 1));
    endfunction

    function automatic logic [1:0] exp_sel(input int c);
        return (seq_valid && (c >= seq_t + B + 1)) ? seq_tgt : old_gain;
    endfunction

    function automatic logic [1:0] exp_applied(input int c);
        return (seq_valid && (c >= seq_t + B + 2)) ? seq_tgt : old_gain;
    endfunction

    function automatic int exp_count(input int c);
        return (c >= dv_rise) ? count_new : count_old;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks = n_checks + 1;
        if (act !== exp_v) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] req, input logic stable, input logic r, input int n);
        gain_req    = req;
        gain_stable = stable;
        rst         = r;
        repeat (n) @(posedge adc_clk);
        #1;
    endtask

    // Reference model: consumes the inputs of the cycle ending at this edge
    always @(posedge adc_clk) begin
        int         c;
        logic [1:0] cur;
        int         cnt;
        c = cyc;
        if (rst === 1'b1) begin
            model_valid = 1'b1;
            seq_valid   = 1'b0;
            old_gain    = 2'd0;
            count_old   = 0;
            count_new   = 0;
            dv_rise     = c + 1 + S;
            sb_q.delete();
            sb_q.push_back('{gain: 2'd0, count: 0, at: c + 1 + S});
        end else if (exp_dv(c) && (gain_req != exp_applied(c))) begin
            cur       = exp_applied(c);
            cnt       = exp_count(c);
            old_gain  = cur;
            count_old = cnt;
            count_new = (cnt < CMAX) ? cnt + 1 : CMAX;
            seq_valid = 1'b1;
            seq_t     = c;
            seq_tgt   = gain_req;
            dv_rise   = c + B + S + 2;
            sb_q.push_back('{gain: gain_req, count: count_new, at: dv_rise});
        end
        cyc = cyc + 1;
    end

    // Monitor: per-cycle output checks plus scoreboard pop on each data_valid rise
    always @(negedge adc_clk) begin
        exp_t e;
        if (model_valid) begin
            check_output("sw_en", 32'(sw_en), 32'(exp_en(cyc)));
            check_output("sw_sel", 32'(sw_sel), 32'(exp_sel(cyc)));
            check_output("gain_applied", 32'(gain_applied), 32'(exp_applied(cyc)));
            check_output("data_valid", 32'(data_valid), 32'(exp_dv(cyc)));
            check_output("busy", 32'(busy), 32'(!exp_dv(cyc)));
            check_output("switch_count", 32'(switch_count), 32'(exp_count(cyc)));
            check_output("gain_locked", 32'(gain_locked),
                         32'(exp_dv(cyc) && gain_stable && (gain_req == exp_applied(cyc))));
            if (have_prev && !prev_rst && prev_en && sw_en) begin
                check_output("sel_hold", 32'(sw_sel), 32'(prev_sel));
            end
            if (have_prev && (data_valid === 1'b1) && (prev_dv === 1'b0)) begin
                if (sb_q.size() == 0) begin
                    check_output("sb_unexpected_rise", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_output("sb_gain", 32'(gain_applied), 32'(e.gain));
                    check_output("sb_count", 32'(switch_count), 32'(e.count));
                    check_output("sb_cycle", 32'(cyc), 32'(e.at));
                end
            end
            have_prev = 1'b1;
        end
        prev_rst = rst;
        prev_en  = sw_en;
        prev_sel = sw_sel;
        prev_dv  = data_valid;
    end

    initial begin
        logic [1:0] req;
        logic       r;
        // Power-up: reset for three cycles, then the settle period
        apply_stimulus(2'd0, 1'b0, 1'b1, 3);
        apply_stimulus(2'd0, 1'b0, 1'b0, 20);
        // Single switch 0 -> 2
        apply_stimulus(2'd2, 1'b0, 1'b0, 30);
        // 2 -> 1, then 3 requested while breaking
        apply_stimulus(2'd1, 1'b0, 1'b0, 2);
        apply_stimulus(2'd3, 1'b0, 1'b0, 60);
        // Back to 0, then 0 -> 1 with a return to 0 during settle
        apply_stimulus(2'd0, 1'b0, 1'b0, 30);
        apply_stimulus(2'd1, 1'b0, 1'b0, 10);
        apply_stimulus(2'd0, 1'b0, 1'b0, 60);
        // Reset in the middle of settling at gain 3
        apply_stimulus(2'd3, 1'b0, 1'b0, 10);
        apply_stimulus(2'd3, 1'b0, 1'b1, 1);
        apply_stimulus(2'd0, 1'b0, 1'b0, 25);
        // Lock indication across a 1 -> 2 switch with the AGC stable
        apply_stimulus(2'd1, 1'b1, 1'b0, 30);
        apply_stimulus(2'd2, 1'b1, 1'b0, 30);
        // Enough back-to-back switches to saturate the narrow counter
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(2'((3 + i) % 4), 1'b1, 1'b0, 25);
        end
        // Random requests, lock input and occasional resets
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            req = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : gain_req;
            apply_stimulus(req, 1'($urandom_range(0, 1)), r, 1);
        end
        // Drain with a steady request so every pending sequence completes
        apply_stimulus(gain_req, 1'b1, 1'b0, 60);
        check_output("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
